// File: rtl/cnn_mem_ctrl.sv
// Multi-region bus-loaded memory plus CNN layer sequencer (IDLE/RUN/DONE).
// Optional inference-complete interrupt enabled by defining CNN_MEM_IRQ_EN.
//
// state  | meaning
// S_IDLE | host loading regions, waiting for start
// S_RUN  | layer k started, waiting for layer_done[k]
// S_DONE | all layers finished, output region readable
module cnn_mem_ctrl #(
  parameter int DATA_W      = 8,
  parameter int NUM_REGIONS = 6,
  parameter int REGION_AW   = 16,
  parameter int ADDR_W      = 19,
  parameter int NUM_LAYERS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic                  eng_rd_en,
  input  logic [2:0]            eng_rd_region,
  input  logic [REGION_AW-1:0]  eng_rd_addr,
  output logic [DATA_W-1:0]     eng_rd_data,
  input  logic                  eng_wr_en,
  input  logic [REGION_AW-1:0]  eng_wr_addr,
  input  logic [DATA_W-1:0]     eng_wr_data,
  output logic                  busy,
  output logic                  irq
);

  localparam int NW = NUM_REGIONS - 1;
  localparam int KW = 3;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 entry_q, entry_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [REGION_AW-1:0] ptr_q [NW];
  logic [REGION_AW-1:0] ptr_d [NW];
  logic [REGION_AW-1:0] limit_q [NW];
  logic [REGION_AW-1:0] limit_d [NW];
  logic                 rd_vld_q, rd_vld_d;
  logic                 rd_out_q, rd_out_d;
  logic [DATA_W-1:0]    reg_rd_q, reg_rd_d;
  logic [DATA_W-1:0]    out_rd_q;
  logic                 eng_vld_q, eng_vld_d;
  logic [2:0]           eng_sel_q, eng_sel_d;
  logic [NUM_REGIONS-1:0][DATA_W-1:0] eng_mem;
  logic [NW-1:0]        loaded, stream_we;
  logic                 all_loaded, cur_done;

  logic [1:0] win;
  logic [7:0] off;
  logic       bus_wr, bus_rd, ctrl_wr, start_cmd, clear_cmd, abort_cmd, clear_ok;
  logic       status_rd, out_rd_en, stream_wr;
  logic       unused_bits;

  assign win       = address[ADDR_W-1:ADDR_W-2];
  assign off       = address[7:0];
  assign bus_wr    = chipselect & write;
  assign bus_rd    = chipselect & read;
  assign ctrl_wr   = bus_wr && win == 2'b10 && off == 8'h00;
  assign start_cmd = ctrl_wr & writedata[0];
  assign clear_cmd = ctrl_wr & writedata[1];
  assign abort_cmd = ctrl_wr & writedata[2];
  assign clear_ok  = clear_cmd && state_q != S_RUN;
  assign status_rd = bus_rd && win == 2'b10 && off == 8'h01;
  assign out_rd_en = bus_rd && win == 2'b01;
  assign stream_wr = bus_wr && win == 2'b00;
  assign unused_bits = ^address[ADDR_W-3:REGION_AW];

  always_comb begin
    cur_done = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (k_q == KW'(i)) cur_done = layer_done[i];
  end

  always_comb begin
    loaded = '0;
    for (int r = 0; r < NW; r++) loaded[r] = (ptr_q[r] == limit_q[r]);
    all_loaded = &loaded;
  end

  // state register (FSM and datapath flops)
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      entry_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_out_q  <= 1'b0;
      reg_rd_q  <= '0;
      eng_vld_q <= 1'b0;
      eng_sel_q <= '0;
      for (int r = 0; r < NW; r++) begin
        ptr_q[r]   <= '0;
        limit_q[r] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      entry_q   <= entry_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_vld_q  <= rd_vld_d;
      rd_out_q  <= rd_out_d;
      reg_rd_q  <= reg_rd_d;
      eng_vld_q <= eng_vld_d;
      eng_sel_q <= eng_sel_d;
      ptr_q     <= ptr_d;
      limit_q   <= limit_d;
    end
  end

  // next-state
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    entry_d = 1'b0;
    done_d  = done_q;
    if (abort_cmd) begin
      state_d = S_IDLE;
      k_d     = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (start_cmd && all_loaded) begin
          state_d = S_RUN;
          k_d     = '0;
          entry_d = 1'b1;
        end
        S_RUN: if (cur_done) begin
          if (k_q == KW'(NUM_LAYERS - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            k_d     = k_q + 3'd1;
            entry_d = 1'b1;
          end
        end
        S_DONE: if (clear_cmd) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end else if (start_cmd) begin
          state_d = S_RUN;
          k_d     = '0;
          entry_d = 1'b1;
          done_d  = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs
  always_comb begin
    busy = (state_q == S_RUN);
    for (int i = 0; i < NUM_LAYERS; i++)
      layer_start[i] = entry_q && state_q == S_RUN && k_q == KW'(i);
  end

  always_comb begin
    logic [15:0] lim;
    lim       = '0;
    ptr_d     = ptr_q;
    limit_d   = limit_q;
    err_d     = err_q;
    stream_we = '0;
    if (stream_wr) begin
      for (int r = 0; r < NW; r++) begin
        if (address[2:0] == 3'(r)) begin
          if (state_q != S_IDLE || loaded[r]) err_d = 1'b1;
          else begin
            stream_we[r] = 1'b1;
            ptr_d[r]     = ptr_q[r] + REGION_AW'(1);
          end
        end
      end
    end
    if (start_cmd && !abort_cmd && state_q == S_IDLE && !all_loaded) err_d = 1'b1;
    if (bus_wr && win == 2'b10) begin
      for (int r = 0; r < NW; r++) begin
        lim = 16'(limit_q[r]);
        if (off == 8'(16 + 2 * r)) begin
          lim[7:0]   = writedata[7:0];
          limit_d[r] = REGION_AW'(lim);
        end
        if (off == 8'(17 + 2 * r)) begin
          lim[15:8]  = writedata[7:0];
          limit_d[r] = REGION_AW'(lim);
        end
      end
    end
    // limits survive clear so the host can reload with the same layout
    if (clear_ok) begin
      err_d = 1'b0;
      for (int r = 0; r < NW; r++) ptr_d[r] = '0;
    end
  end

  always_comb begin
    rd_vld_d  = bus_rd;
    rd_out_d  = out_rd_en;
    reg_rd_d  = '0;
    if (status_rd) reg_rd_d = DATA_W'({err_q, all_loaded, done_q, state_q == S_RUN});
    eng_vld_d = eng_rd_en && ({1'b0, eng_rd_region} < 4'(NUM_REGIONS));
    eng_sel_d = eng_rd_region;
  end

  assign readdata      = rd_out_q ? out_rd_q : reg_rd_q;
  assign readdatavalid = rd_vld_q;
  assign eng_rd_data   = eng_vld_q ? eng_mem[eng_sel_q] : '0;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_region
    logic [DATA_W-1:0]    mem [2**REGION_AW];
    logic [DATA_W-1:0]    rd_q;
    logic                 we;
    logic [REGION_AW-1:0] wa;
    logic [DATA_W-1:0]    wd;
    if (g == NUM_REGIONS - 1) begin : g_out
      assign we = eng_wr_en;
      assign wa = eng_wr_addr;
      assign wd = eng_wr_data;
      always_ff @(posedge clk)
        if (out_rd_en) out_rd_q <= mem[address[REGION_AW-1:0]];
    end else begin : g_in
      assign we = stream_we[g];
      assign wa = ptr_q[g];
      assign wd = writedata;
    end
    // reads sample the array before this edge's write lands: read-old-data
    always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (eng_rd_en) rd_q <= mem[eng_rd_addr];
    end
    assign eng_mem[g] = rd_q;
  end

`ifdef CNN_MEM_IRQ_EN
  logic irq_q, irq_d;
  always_comb begin
    irq_d = irq_q;
    if (status_rd || clear_ok || abort_cmd) irq_d = 1'b0;
    if (state_q != S_DONE && state_d == S_DONE) irq_d = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq_d;
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule
